// File: rtl/ntt_pkg.sv
// Shared constants for the NTT sequencer: parameter defaults, FSM encodings
// and a stage-index width helper.
package ntt_pkg;

  localparam int LOGN_DEF       = 8;
  localparam int LAT_BASE_DEF   = 4;
  localparam int MEM_RD_LAT_DEF = 1;
  localparam int LAT_SEL_MAX    = 3;
  localparam int MAX_D          = MEM_RD_LAT_DEF + LAT_BASE_DEF + LAT_SEL_MAX;

  // FSM encodings (kept as plain constants for legacy tool flows)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Bits needed to hold a stage index 0..logn-1
  function automatic int stage_width(input int logn);
    return (logn > 1) ? $clog2(logn) : 1;
  endfunction

endpackage

// File: rtl/ntt_ctrl_if.sv
// Command / memory-side bundle of the NTT sequencer. The master drives the
// command, the slave (the sequencer) drives everything else.
interface ntt_ctrl_if import ntt_pkg::*; #(
  parameter int LOGN = LOGN_DEF
);
  localparam int SW = stage_width(LOGN);

  logic            start;
  logic            mode_ct;
  logic [1:0]      lat_sel;
  logic            busy;
  logic            done;
  logic            ct;
  logic [1:0]      i_sel;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [LOGN-1:0] tw_addr;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;
  logic [SW-1:0]   stage;

  modport master (
    output start, mode_ct, lat_sel,
    input  busy, done, ct, i_sel, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, stage
  );

  modport slave (
    input  start, mode_ct, lat_sel,
    output busy, done, ct, i_sel, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, stage
  );

endinterface

// File: rtl/ntt_addr_delay.sv
// Shift register of {en, addr_a, addr_b}; the tap picks a delay of 1..DEPTH
// cycles so write-back lines up with the butterfly output.
module ntt_addr_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] tap,
  input  logic          in_en,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_en,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b
);

  logic [DEPTH-1:0]         en_sr;
  logic [DEPTH-1:0][W-1:0]  a_sr;
  logic [DEPTH-1:0][W-1:0]  b_sr;

  // Shift one entry per cycle; reset flushes anything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sr <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else begin
      en_sr <= {en_sr[DEPTH-2:0], in_en};
      a_sr  <= {a_sr[DEPTH-2:0], in_a};
      b_sr  <= {b_sr[DEPTH-2:0], in_b};
    end
  end

  // Select the register whose age equals the requested delay
  always_comb begin
    out_en = 1'b0;
    out_a  = '0;
    out_b  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap == DW'(i + 1)) begin
        out_en = en_sr[i];
        out_a  = a_sr[i];
        out_b  = b_sr[i];
      end
    end
  end

endmodule

// File: rtl/ntt_ctrl.sv
// In-place NTT/INTT sequencer for a single butterfly: issues read pairs and
// twiddle addresses stage by stage, drains the pipeline between stages, and
// replays the addresses as write-backs D cycles later.
module ntt_ctrl import ntt_pkg::*; #(
  parameter int LOGN       = LOGN_DEF,
  parameter int LAT_BASE   = LAT_BASE_DEF,
  parameter int MEM_RD_LAT = MEM_RD_LAT_DEF
) (
  input  logic      clk,
  input  logic      reset,
  ntt_ctrl_if.slave bus
);

  localparam int SW    = stage_width(LOGN);
  localparam int KW    = LOGN - 1;
  localparam int DEPTH = MEM_RD_LAT + LAT_BASE + LAT_SEL_MAX;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};

  logic [1:0]      state_r, state_nxt;
  logic [KW-1:0]   k_r, k_nxt;
  logic [SW-1:0]   stage_r, stage_nxt;
  logic [DW-1:0]   dcnt_r, dcnt_nxt;
  logic            ct_r, ct_nxt;
  logic [1:0]      isel_r, isel_nxt;
  logic [DW-1:0]   d_s;

  logic            rd_en_r, busy_r, done_r;
  logic [LOGN-1:0] rd_a_r, rd_b_r, tw_r;

  int              e_s;
  logic [LOGN-1:0] kk_s, len_s, grp_s, off_s, a_s, b_s, tw_s;
  logic            wr_en_s;
  logic [LOGN-1:0] wr_a_s, wr_b_s;

  // Total pipeline delay is frozen once lat_sel has been latched
  assign d_s = DW'(MEM_RD_LAT + LAT_BASE) + DW'(isel_r);

  // Next-state logic for FSM, butterfly counter, stage and drain counter
  always_comb begin
    state_nxt = state_r;
    k_nxt     = k_r;
    stage_nxt = stage_r;
    dcnt_nxt  = dcnt_r;
    ct_nxt    = ct_r;
    isel_nxt  = isel_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          ct_nxt    = bus.mode_ct;
          isel_nxt  = bus.lat_sel;
          stage_nxt = '0;
          k_nxt     = '0;
          state_nxt = ST_ISSUE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (k_r == K_LAST) begin
          k_nxt     = '0;
          dcnt_nxt  = '0;
          state_nxt = ST_DRAIN;
        end else begin
          k_nxt = k_r + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (dcnt_r == d_s - DW'(1)) begin
          dcnt_nxt = '0;
          if (stage_r == SW'(LOGN - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            stage_nxt = stage_r + SW'(1);
            state_nxt = ST_ISSUE;
          end
        end else begin
          dcnt_nxt = dcnt_r + DW'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Addresses for the butterfly about to be issued. e is log2 of the pair
  // distance: CT halves it each stage, GS doubles it; the twiddle base is
  // then 2^(LOGN-1-e) in both directions.
  always_comb begin
    e_s   = ct_nxt ? (LOGN - 1 - int'(stage_nxt)) : int'(stage_nxt);
    kk_s  = {1'b0, k_nxt};
    len_s = LOGN'(1) << e_s;
    grp_s = kk_s >> e_s;
    off_s = kk_s & (len_s - LOGN'(1));
    a_s   = (grp_s << (e_s + 1)) + off_s;
    b_s   = a_s + len_s;
    tw_s  = (LOGN'(1) << (LOGN - 1 - e_s)) + grp_s;
  end

  // State registers and registered outputs derived from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      k_r     <= '0;
      stage_r <= '0;
      dcnt_r  <= '0;
      ct_r    <= 1'b0;
      isel_r  <= 2'd0;
      rd_en_r <= 1'b0;
      rd_a_r  <= '0;
      rd_b_r  <= '0;
      tw_r    <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      k_r     <= k_nxt;
      stage_r <= stage_nxt;
      dcnt_r  <= dcnt_nxt;
      ct_r    <= ct_nxt;
      isel_r  <= isel_nxt;
      rd_en_r <= (state_nxt == ST_ISSUE);
      rd_a_r  <= (state_nxt == ST_ISSUE) ? a_s  : '0;
      rd_b_r  <= (state_nxt == ST_ISSUE) ? b_s  : '0;
      tw_r    <= (state_nxt == ST_ISSUE) ? tw_s : '0;
      busy_r  <= (state_nxt != ST_IDLE);
      done_r  <= (state_nxt == ST_DONE);
    end
  end

  ntt_addr_delay #(
    .W     (LOGN),
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_dly (
    .clk    (clk),
    .reset  (reset),
    .tap    (d_s),
    .in_en  (rd_en_r),
    .in_a   (rd_a_r),
    .in_b   (rd_b_r),
    .out_en (wr_en_s),
    .out_a  (wr_a_s),
    .out_b  (wr_b_s)
  );

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.ct        = ct_r;
  assign bus.i_sel     = isel_r;
  assign bus.rd_en     = rd_en_r;
  assign bus.rd_addr_a = rd_a_r;
  assign bus.rd_addr_b = rd_b_r;
  assign bus.tw_addr   = tw_r;
  assign bus.wr_en     = wr_en_s;
  assign bus.wr_addr_a = wr_a_s;
  assign bus.wr_addr_b = wr_b_s;
  assign bus.stage     = stage_r;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl at LOGN=3 against the hand-computed address
// tables and cycle timings of the 8-point transform.
module tb_ntt_ctrl;

  localparam int LOGN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ntt_ctrl_if #(.LOGN(LOGN)) bus();

  ntt_ctrl #(.LOGN(LOGN), .LAT_BASE(4), .MEM_RD_LAT(1)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expected read pairs / twiddles in issue order (stage = index / 4)
  int ct_a [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int ct_b [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int ct_t [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
  int gs_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int gs_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int gs_t [12] = '{4, 5, 6, 7, 2, 2, 3, 3, 1, 1, 1, 1};

  logic [10:0] rd_v[$];
  int          rd_c[$];
  logic [5:0]  wr_v[$];
  int          wr_c[$];

  // Expected {addr_a, addr_b, tw, stage} for the i-th issued butterfly
  function automatic logic [10:0] exp_rd(input logic m, input int i);
    logic [2:0] a, b, t;
    if (m) begin
      a = 3'(ct_a[i]); b = 3'(ct_b[i]); t = 3'(ct_t[i]);
    end else begin
      a = 3'(gs_a[i]); b = 3'(gs_b[i]); t = 3'(gs_t[i]);
    end
    return {a, b, t, 2'(i / 4)};
  endfunction

  // Expected {wr_addr_a, wr_addr_b} for the i-th write-back
  function automatic logic [5:0] exp_wr(input logic m, input int i);
    logic [10:0] r;
    r = exp_rd(m, i);
    return r[10:5];
  endfunction

  // Cycle (after start) at which the i-th read is issued, pipeline delay d
  function automatic int exp_cyc(input int i, input int d);
    return 1 + (i / 4) * (4 + d) + (i % 4);
  endfunction

  // Start one transform and record reads/writes until done or budget runs out
  task automatic run_xform(input logic m, input logic [1:0] ls, input int restart_at,
                           output int done_cyc, output int busy_gaps);
    rd_v.delete(); rd_c.delete(); wr_v.delete(); wr_c.delete();
    done_cyc    = -1;
    busy_gaps   = 0;
    bus.mode_ct = m;
    bus.lat_sel = ls;
    bus.start   = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.start = (c == restart_at);
      if (c == restart_at) begin
        bus.mode_ct = ~m;
        bus.lat_sel = ~ls;
      end
      if (bus.rd_en) begin
        rd_v.push_back({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.stage});
        rd_c.push_back(c);
      end
      if (bus.wr_en) begin
        wr_v.push_back({bus.wr_addr_a, bus.wr_addr_b});
        wr_c.push_back(c);
      end
      if (!bus.busy) busy_gaps++;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.mode_ct = 1'b1; bus.lat_sel = 2'd3;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.ct, bus.i_sel, bus.rd_en, bus.wr_en, bus.stage} !== 9'd0)
      $display("FAIL reset_ctrl: got %b want 0",
               {bus.busy, bus.done, bus.ct, bus.i_sel, bus.rd_en, bus.wr_en, bus.stage});
    else n_pass++;
    n_checks++;
    if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b} !== 15'd0)
      $display("FAIL reset_addr: got %h want 0",
               {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.rd_en, bus.wr_en} !== 3'd0)
      $display("FAIL idle_after_reset: got %b want 000", {bus.busy, bus.rd_en, bus.wr_en});
    else n_pass++;
  endtask

  task automatic test_ct;
    int dc, bg;
    repeat (2) @(negedge clk);
    run_xform(1'b1, 2'd0, 0, dc, bg);
    n_checks++;
    if (rd_v.size() != 12) $display("FAIL ct_rd_count: got %0d want 12", rd_v.size());
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (i >= rd_v.size() || rd_v[i] !== exp_rd(1'b1, i) || rd_c[i] != exp_cyc(i, 5))
        $display("FAIL ct_rd[%0d]: got %h @%0d want %h @%0d", i, rd_v[i], rd_c[i],
                 exp_rd(1'b1, i), exp_cyc(i, 5));
      else n_pass++;
    end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (i >= wr_v.size() || wr_v[i] !== exp_wr(1'b1, i) || wr_c[i] != exp_cyc(i, 5) + 5)
        $display("FAIL ct_wr[%0d]: got %h @%0d want %h @%0d", i, wr_v[i], wr_c[i],
                 exp_wr(1'b1, i), exp_cyc(i, 5) + 5);
      else n_pass++;
    end
    n_checks++;
    if (dc != 28) $display("FAIL ct_done_cycle: got %0d want 28", dc); else n_pass++;
    n_checks++;
    if (bg != 0) $display("FAIL ct_busy: got %0d low cycles want 0", bg); else n_pass++;
    n_checks++;
    if ({bus.ct, bus.i_sel} !== 3'b100) $display("FAIL ct_latch: got %b want 100", {bus.ct, bus.i_sel});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.busy} !== 2'b00) $display("FAIL ct_done_pulse: got %b want 00", {bus.done, bus.busy});
    else n_pass++;
  endtask

  task automatic test_gs;
    int dc, bg;
    repeat (2) @(negedge clk);
    run_xform(1'b0, 2'd0, 0, dc, bg);
    n_checks++;
    if (rd_v.size() != 12) $display("FAIL gs_rd_count: got %0d want 12", rd_v.size());
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (i >= rd_v.size() || rd_v[i] !== exp_rd(1'b0, i) || rd_c[i] != exp_cyc(i, 5))
        $display("FAIL gs_rd[%0d]: got %h @%0d want %h @%0d", i, rd_v[i], rd_c[i],
                 exp_rd(1'b0, i), exp_cyc(i, 5));
      else n_pass++;
    end
    n_checks++;
    if (dc != 28) $display("FAIL gs_done_cycle: got %0d want 28", dc); else n_pass++;
    n_checks++;
    if (bus.ct !== 1'b0) $display("FAIL gs_ct: got %b want 0", bus.ct); else n_pass++;
  endtask

  task automatic test_lat3;
    int dc, bg;
    repeat (2) @(negedge clk);
    run_xform(1'b1, 2'd3, 0, dc, bg);
    n_checks++;
    if (wr_v.size() != 12) $display("FAIL lat3_wr_count: got %0d want 12", wr_v.size());
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (i >= wr_v.size() || wr_v[i] !== exp_wr(1'b1, i) || wr_c[i] != exp_cyc(i, 8) + 8)
        $display("FAIL lat3_wr[%0d]: got %h @%0d want %h @%0d", i, wr_v[i], wr_c[i],
                 exp_wr(1'b1, i), exp_cyc(i, 8) + 8);
      else n_pass++;
    end
    n_checks++;
    if (dc != 37) $display("FAIL lat3_done_cycle: got %0d want 37", dc); else n_pass++;
    n_checks++;
    if (bus.i_sel !== 2'd3) $display("FAIL lat3_i_sel: got %0d want 3", bus.i_sel); else n_pass++;
  endtask

  task automatic test_restart;
    int dc, bg;
    repeat (2) @(negedge clk);
    run_xform(1'b1, 2'd0, 5, dc, bg);
    n_checks++;
    if (rd_v.size() != 12) $display("FAIL restart_rd_count: got %0d want 12", rd_v.size());
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (i >= rd_v.size() || rd_v[i] !== exp_rd(1'b1, i) || rd_c[i] != exp_cyc(i, 5))
        $display("FAIL restart_rd[%0d]: got %h @%0d want %h @%0d", i, rd_v[i], rd_c[i],
                 exp_rd(1'b1, i), exp_cyc(i, 5));
      else n_pass++;
    end
    n_checks++;
    if (dc != 28) $display("FAIL restart_done_cycle: got %0d want 28", dc); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int dc, bg, stray, stop;
    for (int j = 0; j < 2; j++) begin
      stop = 10 + 2 * j;
      repeat (2) @(negedge clk);
      bus.mode_ct = 1'b1; bus.lat_sel = 2'd0; bus.start = 1'b1;
      for (int c = 1; c <= stop; c++) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
      n_checks++;
      if (bus.rd_en !== 1'b1) $display("FAIL abort%0d_midop: got rd_en=%b want 1", stop, bus.rd_en);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.ct, bus.rd_en, bus.wr_en, bus.stage, bus.rd_addr_a,
           bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b} !== 22'd0)
        $display("FAIL abort%0d_zero: got %h want 0", stop,
                 {bus.busy, bus.done, bus.ct, bus.rd_en, bus.wr_en, bus.stage, bus.rd_addr_a,
                  bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b});
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      repeat (12) begin
        @(negedge clk);
        if (bus.wr_en || bus.rd_en || bus.busy) stray++;
      end
      n_checks++;
      if (stray != 0) $display("FAIL abort%0d_quiet: got %0d active cycles want 0", stop, stray);
      else n_pass++;
    end
    run_xform(1'b0, 2'd0, 0, dc, bg);
    n_checks++;
    if (rd_v.size() != 12 || wr_v.size() != 12)
      $display("FAIL recover_count: got rd=%0d wr=%0d want 12/12", rd_v.size(), wr_v.size());
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (i >= rd_v.size() || rd_v[i] !== exp_rd(1'b0, i) || rd_c[i] != exp_cyc(i, 5))
        $display("FAIL recover_rd[%0d]: got %h @%0d want %h @%0d", i, rd_v[i], rd_c[i],
                 exp_rd(1'b0, i), exp_cyc(i, 5));
      else n_pass++;
    end
    n_checks++;
    if (dc != 28) $display("FAIL recover_done_cycle: got %0d want 28", dc); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int dc, bg;
    repeat (2) @(negedge clk);
    run_xform(1'b1, 2'd0, 0, dc, bg);
    n_checks++;
    if (dc != 28) $display("FAIL b2b_first_done: got %0d want 28", dc); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL b2b_idle_gap: got busy=%b want 0", bus.busy); else n_pass++;
    run_xform(1'b1, 2'd0, 0, dc, bg);
    n_checks++;
    if (rd_v.size() != 12) $display("FAIL b2b_rd_count: got %0d want 12", rd_v.size());
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (i >= rd_v.size() || rd_v[i] !== exp_rd(1'b1, i) || rd_c[i] != exp_cyc(i, 5))
        $display("FAIL b2b_rd[%0d]: got %h @%0d want %h @%0d", i, rd_v[i], rd_c[i],
                 exp_rd(1'b1, i), exp_cyc(i, 5));
      else n_pass++;
    end
    n_checks++;
    if (dc != 28) $display("FAIL b2b_second_done: got %0d want 28", dc); else n_pass++;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.mode_ct = 1'b0;
    bus.lat_sel = 2'd0;
    test_reset;
    test_ct;
    test_gs;
    test_lat3;
    test_restart;
    test_reset_abort;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
